// File: rtl/pipe_cla_addsub_pkg.sv
// Shared constants for the pipelined CLA adder/subtractor: default geometry,
// operation encoding and the per-stage chunk width helper.
package pipe_cla_addsub_pkg;

   localparam int unsigned ADDSUB_DEF_WIDTH  = 32;
   localparam int unsigned ADDSUB_DEF_GROUP  = 4;
   localparam int unsigned ADDSUB_DEF_STAGES = 2;
   localparam int unsigned ADDSUB_DEF_TAG_W  = 5;

   localparam logic ADDSUB_OP_ADD = 1'b0;
   localparam logic ADDSUB_OP_SUB = 1'b1;

   // Bits summed by each pipeline stage.
   function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/pipe_cla_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor. The master drives
// operands, flush and out_ready; the slave (the adder) returns in_ready and
// the registered result.
interface pipe_cla_addsub_if
   import pipe_cla_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = ADDSUB_DEF_WIDTH,
   parameter int unsigned TAG_W = ADDSUB_DEF_TAG_W
) ();

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_zero;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output flush, in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf, out_tag
   );

   modport slave (
      input  flush, in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_zero, out_ovf, out_tag
   );

endinterface

// File: rtl/pipe_cla_addsub_cla_chunk.sv
// cla_chunk: combinational CHUNK-bit carry-lookahead adder. Bits are grouped
// GROUP at a time into group generate/propagate terms; a group-level
// lookahead produces each group's carry-in, then bit carries are resolved
// locally inside each group.
module cla_chunk #(
   parameter int unsigned CHUNK = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   localparam int unsigned NGRP = CHUNK / GROUP;

   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP:0]    grp_c;

   assign g = a & b;
   assign p = a ^ b;

   // Group generate/propagate over GROUP bits.
   always_comb begin
      logic gg;
      logic gp;
      grp_g = '0;
      grp_p = '0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int unsigned i = 0; i < GROUP; i++) begin
            gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
            gp = gp & p[j*GROUP+i];
         end
         grp_g[j] = gg;
         grp_p[j] = gp;
      end
   end

   // Group-level lookahead: carry into each group from group g/p only.
   always_comb begin
      logic c;
      grp_c = '0;
      c     = cin;
      for (int unsigned j = 0; j < NGRP; j++) begin
         grp_c[j] = c;
         c        = grp_g[j] | (grp_p[j] & c);
      end
      grp_c[NGRP] = c;
   end

   // Bit sums inside each group, seeded by the group carry.
   always_comb begin
      logic c;
      s = '0;
      c = 1'b0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         c = grp_c[j];
         for (int unsigned i = 0; i < GROUP; i++) begin
            s[j*GROUP+i] = p[j*GROUP+i] ^ c;
            c            = g[j*GROUP+i] | (p[j*GROUP+i] & c);
         end
      end
   end

   assign cout = grp_c[NGRP];

endmodule

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub: pipelined carry-lookahead adder/subtractor. Stage k sums
// operand chunk k; its carry is registered into stage k+1. Between stages a
// single word holds finished low sum bits and the still-pending high A bits,
// alongside the pending high bits of the effective B operand.
// Optional feature macro: ADDSUB_OVF_EN enables the signed-overflow flag;
// without it out_ovf is tied low and no overflow register exists.
module pipe_cla_addsub
   import pipe_cla_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = ADDSUB_DEF_WIDTH,
   parameter int unsigned GROUP  = ADDSUB_DEF_GROUP,
   parameter int unsigned STAGES = ADDSUB_DEF_STAGES,
   parameter int unsigned TAG_W  = ADDSUB_DEF_TAG_W
) (
   input logic               clk,
   input logic               rst,
   pipe_cla_addsub_if.slave  bus
);

   localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

   logic             adv_c;
   logic             acc_c;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_sum_q;
   logic             out_cout_q;
   logic             out_zero_q;
   logic [TAG_W-1:0] out_tag_q;

   // Whole pipe advances together; a stalled output freezes every stage.
   assign adv_c        = !out_valid_q || bus.out_ready;
   assign acc_c        = bus.in_valid && adv_c && !bus.flush;
   assign bus.in_ready = adv_c;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned LO = k * CHUNK;
      localparam int unsigned BW = WIDTH - LO;

      logic [WIDTH-1:0] mx_in;
      logic [BW-1:0]    b_in;
      logic             c_in;
      logic             v_in;
      logic [TAG_W-1:0] t_in;
      logic [CHUNK-1:0] s;
      logic             co;
      logic [WIDTH-1:0] mx_nx;

      if (k == 0) begin : g_src
         // Operand prep: subtraction is A + ~B + ~borrow.
         assign mx_in = bus.in_a;
         assign b_in  = (bus.in_sub == ADDSUB_OP_SUB) ? ~bus.in_b : bus.in_b;
         assign c_in  = (bus.in_sub == ADDSUB_OP_ADD) ? bus.in_cin : ~bus.in_cin;
         assign v_in  = acc_c;
         assign t_in  = bus.in_tag;
      end else begin : g_src
         assign mx_in = g_stg[k-1].g_mid.mx_q;
         assign b_in  = g_stg[k-1].g_mid.b_q;
         assign c_in  = g_stg[k-1].g_mid.cy_q;
         assign v_in  = g_stg[k-1].g_mid.vld_q;
         assign t_in  = g_stg[k-1].g_mid.tag_q;
      end

      cla_chunk #(
         .CHUNK (CHUNK),
         .GROUP (GROUP)
      ) u_cla (
         .a    (mx_in[LO +: CHUNK]),
         .b    (b_in[CHUNK-1:0]),
         .cin  (c_in),
         .s    (s),
         .cout (co)
      );

      // Replace this stage's chunk of A with its sum bits.
      always_comb begin
         mx_nx              = mx_in;
         mx_nx[LO +: CHUNK] = s;
      end

      if (k < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0]    mx_q;
         logic [BW-CHUNK-1:0] b_q;
         logic                cy_q;
         logic                vld_q;
         logic [TAG_W-1:0]    tag_q;

         // Inter-stage register: flush kills valid only, data moves on adv.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
               mx_q  <= '0;
               b_q   <= '0;
               cy_q  <= 1'b0;
               tag_q <= '0;
            end else begin
               if (bus.flush) begin
                  vld_q <= 1'b0;
               end else if (adv_c) begin
                  vld_q <= v_in;
               end
               if (adv_c) begin
                  mx_q  <= mx_nx;
                  b_q   <= b_in[BW-1:CHUNK];
                  cy_q  <= co;
                  tag_q <= t_in;
               end
            end
         end
      end else begin : g_last
         // Output register: full sum, carry, zero flag and tag.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid_q <= 1'b0;
               out_sum_q   <= '0;
               out_cout_q  <= 1'b0;
               out_zero_q  <= 1'b0;
               out_tag_q   <= '0;
            end else begin
               if (bus.flush) begin
                  out_valid_q <= 1'b0;
               end else if (adv_c) begin
                  out_valid_q <= v_in;
               end
               if (adv_c) begin
                  out_sum_q  <= mx_nx;
                  out_cout_q <= co;
                  out_zero_q <= (mx_nx == '0);
                  out_tag_q  <= t_in;
               end
            end
         end

`ifdef ADDSUB_OVF_EN
         logic out_ovf_q;

         // Signed overflow: operands agree in sign but the sum does not.
         always_ff @(posedge clk) begin
            if (rst) begin
               out_ovf_q <= 1'b0;
            end else if (adv_c) begin
               out_ovf_q <= (mx_in[WIDTH-1] == b_in[BW-1]) &&
                            (mx_nx[WIDTH-1] != mx_in[WIDTH-1]);
            end
         end

         assign bus.out_ovf = out_ovf_q;
`else
         assign bus.out_ovf = 1'b0;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_zero  = out_zero_q;
   assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench for pipe_cla_addsub (WIDTH=32, STAGES=2, GROUP=4).
module tb_pipe_cla_addsub;
   import pipe_cla_addsub_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned TW = 5;
`ifdef ADDSUB_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_cla_addsub_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   pipe_cla_addsub #(.WIDTH(W), .GROUP(4), .STAGES(2), .TAG_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        z;
      logic        ov;
      logic [4:0]  tag;
   } exp_t;

   exp_t q[$];

   // Reference: plain integer arithmetic on unbounded values.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input logic [4:0] tag);
      exp_t   e;
      longint ua, ub, r, sa, sb, sr;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         r    = ua - ub - longint'(cin);
         sr   = sa - sb - longint'(cin);
         e.co = (r >= 0);
      end else begin
         r    = ua + ub + longint'(cin);
         sr   = sa + sb + longint'(cin);
         e.co = (r >= 64'sd4294967296);
      end
      e.s   = r[31:0];
      e.z   = (e.s == 32'd0);
      e.ov  = OVF_EN && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
      e.tag = tag;
      return e;
   endfunction

   // Random output back-pressure when enabled.
   bit rand_rdy = 1'b0;
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Compare process: handshake rules, hold-while-stalled, in-order results.
   logic        stall_prev = 1'b0;
   logic [31:0] sum_prev;
   logic [4:0]  tag_prev;
   logic        co_prev, z_prev, ov_prev;

   always @(negedge clk) begin
      exp_t e;
      if (rst || bus.flush) begin
         q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (stall_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_sum", bus.out_sum, sum_prev);
            chk("hold_tag", bus.out_tag, tag_prev);
            chk("hold_flags", {bus.out_cout, bus.out_zero, bus.out_ovf}, {co_prev, z_prev, ov_prev});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", bus.out_valid, 0);
            end else begin
               e = q.pop_front();
               chk("res_tag", bus.out_tag, e.tag);
               chk("res_sum", bus.out_sum, e.s);
               chk("res_cout", bus.out_cout, e.co);
               chk("res_zero", bus.out_zero, e.z);
               chk("res_ovf", bus.out_ovf, e.ov);
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_tag));
         stall_prev = bus.out_valid && !bus.out_ready;
         sum_prev   = bus.out_sum;
         tag_prev   = bus.out_tag;
         co_prev    = bus.out_cout;
         z_prev     = bus.out_zero;
         ov_prev    = bus.out_ovf;
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [4:0] tag);
      bus.in_a   = a;
      bus.in_b   = b;
      bus.in_cin = cin;
      bus.in_sub = sub;
      bus.in_tag = tag;
   endtask

   // Single op into an idle pipe with out_ready=1; checks the 2-cycle latency.
   task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [4:0] tag,
                        input logic [31:0] es, input logic eco, input logic ez, input logic eov);
      drive(a, b, cin, sub, tag);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({name, "_lat1_valid"}, bus.out_valid, 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, bus.out_valid, 1);
      chk({name, "_sum"}, bus.out_sum, es);
      chk({name, "_cout"}, bus.out_cout, eco);
      chk({name, "_zero"}, bus.out_zero, ez);
      chk({name, "_ovf"}, bus.out_ovf, eov);
      chk({name, "_tag"}, bus.out_tag, tag);
   endtask

   // Two ops in flight with the result stalled at the output.
   task automatic load_two();
      bus.out_ready = 1'b0;
      drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 5'd9);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      drive(32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1, 5'd10);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("two_inflight_valid", bus.out_valid, 1);
   endtask

   initial begin
      bit acc;
      int waitc;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_sum", bus.out_sum, 0);
      chk("rst_tag", bus.out_tag, 0);
      chk("rst_flags", {bus.out_cout, bus.out_zero, bus.out_ovf}, 3'b000);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // Directed vectors with hand-computed results.
      do_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADDSUB_OP_ADD, 5'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      do_op("add_cross",  32'h0000_FFFF, 32'h0000_0001, 1'b0, ADDSUB_OP_ADD, 5'd2, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      do_op("sub_neg",    32'd5,         32'd7,         1'b0, ADDSUB_OP_SUB, 5'd3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      do_op("sub_pos",    32'd7,         32'd5,         1'b0, ADDSUB_OP_SUB, 5'd4, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
      do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADDSUB_OP_ADD, 5'd5, 32'h8000_0000, 1'b0, 1'b0, OVF_EN);
      do_op("add_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, ADDSUB_OP_ADD, 5'd6, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      do_op("sub_borrow", 32'd10,        32'd3,         1'b1, ADDSUB_OP_SUB, 5'd7, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
      do_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, ADDSUB_OP_SUB, 5'd8, 32'h7FFF_FFFF, 1'b1, 1'b0, OVF_EN);
      @(posedge clk); #1;

      // 16 back-to-back ops under random back-pressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive($urandom, (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'(i));
         bus.in_valid = 1'b1;
         waitc = 0;
         acc   = 1'b0;
         while (!acc && waitc < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            waitc++;
         end
         if (!acc) chk("accept_timeout", acc, 1);
      end
      bus.in_valid = 1'b0;
      waitc = 0;
      while (q.size() != 0 && waitc < 200) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("drain_left", q.size(), 0);
      @(negedge clk); #1;
      rand_rdy      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Flush with two ops in flight.
      load_two();
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_valid", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("flush_quiet", bus.out_valid, 0);
      end

      // An op presented together with flush is discarded.
      drive(32'd1, 32'd1, 1'b0, 1'b0, 5'd11);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("flush_same_cycle", bus.out_valid, 0);
      end
      do_op("post_flush", 32'h0000_0100, 32'h0000_0023, 1'b0, ADDSUB_OP_ADD, 5'd12, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Reset with two ops in flight.
      load_two();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst2_valid", bus.out_valid, 0);
      chk("rst2_sum", bus.out_sum, 0);
      chk("rst2_tag", bus.out_tag, 0);
      chk("rst2_flags", {bus.out_cout, bus.out_zero, bus.out_ovf}, 3'b000);
      chk("rst2_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst2_quiet", bus.out_valid, 0);
      end
      do_op("post_rst", 32'h0000_0000, 32'h0000_0000, 1'b0, ADDSUB_OP_SUB, 5'd13, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
